datapath: RTL and testbench



---
 rtl/datapath_pkg.sv | 23 ++
 rtl/datapath_reg_n.sv | 19 +
 rtl/datapath.sv | 107 ++++++++++
 tb/tb_datapath.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus teaching CPU datapath:
// bus width, bus-source priority order and ALU operation encoding.
package datapath_pkg;

    localparam int WIDTH = 32;

    // Enumeration order follows bus priority, highest first after SRC_NONE.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_MDR  = 3'd1,
        SRC_ZLOW = 3'd2,
        SRC_PC   = 3'd3,
        SRC_R2   = 3'd4,
        SRC_R3   = 3'd5
    } bus_src_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_AND  = 2'd1,
        ALU_INC  = 2'd2
    } alu_op_e;

endpackage

// File: rtl/datapath_reg_n.sv
// Generic WIDTH-bit register with load enable and asynchronous active-low clear.
module reg_n #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: general registers R1-R3, PC, IR, MAR, MDR, Y and a
// 64-bit Z, all joined by one priority-muxed bus feeding a small ALU.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH  = datapath_pkg::WIDTH,
    parameter int PC_INC = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             AND,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] R1_q,
    output logic [WIDTH-1:0] R2_q,
    output logic [WIDTH-1:0] R3_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] MDR_q,
    output logic [WIDTH-1:0] Y_q,
    output logic [WIDTH-1:0] Zlow_q,
    output logic [WIDTH-1:0] Zhigh_q
);

    bus_src_e             bus_src;
    alu_op_e              alu_op;
    logic [WIDTH-1:0]     bus;
    logic [WIDTH-1:0]     mdr_d;
    logic [2*WIDTH-1:0]   alu_c;

    always_comb begin
        bus_src = SRC_NONE;
        if (MDRout)
            bus_src = SRC_MDR;
        else if (Zlowout)
            bus_src = SRC_ZLOW;
        else if (PCout)
            bus_src = SRC_PC;
        else if (R2out)
            bus_src = SRC_R2;
        else if (R3out)
            bus_src = SRC_R3;
    end

    always_comb begin
        bus = '0;
        case (bus_src)
            SRC_MDR:  bus = MDR_q;
            SRC_ZLOW: bus = Zlow_q;
            SRC_PC:   bus = PC_q;
            SRC_R2:   bus = R2_q;
            SRC_R3:   bus = R3_q;
            default:  bus = '0;
        endcase
    end

    assign BusMuxOut = bus;

    // IncPC wins over AND so a fetch step never depends on a stray AND strobe.
    always_comb begin
        alu_op = ALU_PASS;
        if (IncPC)
            alu_op = ALU_INC;
        else if (AND)
            alu_op = ALU_AND;
    end

    always_comb begin
        alu_c = '0;
        case (alu_op)
            ALU_INC:  alu_c = {{WIDTH{1'b0}}, bus + WIDTH'(PC_INC)};
            ALU_AND:  alu_c = {{WIDTH{1'b0}}, Y_q & bus};
            default:  alu_c = {{WIDTH{1'b0}}, bus};
        endcase
    end

    assign mdr_d = Read ? Mdatain : bus;

    reg_n #(.WIDTH(WIDTH)) u_r1    (.Clock(Clock), .Resetn(Resetn), .en(R1in),  .d(bus),   .q(R1_q));
    reg_n #(.WIDTH(WIDTH)) u_r2    (.Clock(Clock), .Resetn(Resetn), .en(R2in),  .d(bus),   .q(R2_q));
    reg_n #(.WIDTH(WIDTH)) u_r3    (.Clock(Clock), .Resetn(Resetn), .en(R3in),  .d(bus),   .q(R3_q));
    reg_n #(.WIDTH(WIDTH)) u_pc    (.Clock(Clock), .Resetn(Resetn), .en(PCin),  .d(bus),   .q(PC_q));
    reg_n #(.WIDTH(WIDTH)) u_ir    (.Clock(Clock), .Resetn(Resetn), .en(IRin),  .d(bus),   .q(IR_q));
    reg_n #(.WIDTH(WIDTH)) u_mar   (.Clock(Clock), .Resetn(Resetn), .en(MARin), .d(bus),   .q(MAR_q));
    reg_n #(.WIDTH(WIDTH)) u_mdr   (.Clock(Clock), .Resetn(Resetn), .en(MDRin), .d(mdr_d), .q(MDR_q));
    reg_n #(.WIDTH(WIDTH)) u_y     (.Clock(Clock), .Resetn(Resetn), .en(Yin),   .d(bus),   .q(Y_q));
    reg_n #(.WIDTH(WIDTH)) u_zlow  (.Clock(Clock), .Resetn(Resetn), .en(Zin),   .d(alu_c[WIDTH-1:0]),       .q(Zlow_q));
    reg_n #(.WIDTH(WIDTH)) u_zhigh (.Clock(Clock), .Resetn(Resetn), .en(Zin),   .d(alu_c[2*WIDTH-1:WIDTH]), .q(Zhigh_q));

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed test-plan sequences followed by
// randomized strobe patterns checked against a register-file reference model.
module tb_datapath;

    localparam int PC_INC = 1;
    localparam int NREG   = 10;
    localparam int I_R1 = 0, I_R2 = 1, I_R3 = 2, I_PC = 3, I_IR = 4,
                   I_MAR = 5, I_MDR = 6, I_Y = 7, I_ZL = 8, I_ZH = 9;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        PCout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        IncPC, Read, AND;
    logic        R1in, R2in, R3in;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;
    logic [31:0] R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q, Zhigh_q;

    logic [31:0] mr [NREG];
    int total = 0;
    int bad   = 0;

    datapath #(.WIDTH(32), .PC_INC(PC_INC)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .AND(AND),
        .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
        .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q), .IR_q(IR_q),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q), .Zlow_q(Zlow_q), .Zhigh_q(Zhigh_q)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_strobes();
        {PCout, Zlowout, MDRout, R2out, R3out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin}   = '0;
        {IncPC, Read, AND, R1in, R2in, R3in}   = '0;
    endtask

    function automatic logic [31:0] ref_bus();
        if (MDRout)  return mr[I_MDR];
        if (Zlowout) return mr[I_ZL];
        if (PCout)   return mr[I_PC];
        if (R2out)   return mr[I_R2];
        if (R3out)   return mr[I_R3];
        return 32'h0;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".R1"},  R1_q,    mr[I_R1]);
        chk({tag, ".R2"},  R2_q,    mr[I_R2]);
        chk({tag, ".R3"},  R3_q,    mr[I_R3]);
        chk({tag, ".PC"},  PC_q,    mr[I_PC]);
        chk({tag, ".IR"},  IR_q,    mr[I_IR]);
        chk({tag, ".MAR"}, MAR_q,   mr[I_MAR]);
        chk({tag, ".MDR"}, MDR_q,   mr[I_MDR]);
        chk({tag, ".Y"},   Y_q,     mr[I_Y]);
        chk({tag, ".ZL"},  Zlow_q,  mr[I_ZL]);
        chk({tag, ".ZH"},  Zhigh_q, mr[I_ZH]);
    endtask

    // One clock step with the strobes currently applied; the model is updated
    // at the edge and every register is compared afterwards.
    task automatic step(input string tag);
        logic [31:0] b, c;
        #1;
        b = ref_bus();
        chk({tag, ".bus"}, BusMuxOut, b);
        if (IncPC)    c = b + PC_INC;
        else if (AND) c = mr[I_Y] & b;
        else          c = b;
        @(posedge Clock);
        if (R1in)  mr[I_R1]  = b;
        if (R2in)  mr[I_R2]  = b;
        if (R3in)  mr[I_R3]  = b;
        if (PCin)  mr[I_PC]  = b;
        if (IRin)  mr[I_IR]  = b;
        if (MARin) mr[I_MAR] = b;
        if (Yin)   mr[I_Y]   = b;
        if (MDRin) mr[I_MDR] = Read ? Mdatain : b;
        if (Zin) begin
            mr[I_ZL] = c;
            mr[I_ZH] = 32'h0;
        end
        #1;
        check_regs(tag);
        clr_strobes();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".bus"}, BusMuxOut, 32'h0);
        chk({tag, ".R1"},  R1_q,    32'h0);
        chk({tag, ".R2"},  R2_q,    32'h0);
        chk({tag, ".R3"},  R3_q,    32'h0);
        chk({tag, ".PC"},  PC_q,    32'h0);
        chk({tag, ".IR"},  IR_q,    32'h0);
        chk({tag, ".MAR"}, MAR_q,   32'h0);
        chk({tag, ".MDR"}, MDR_q,   32'h0);
        chk({tag, ".Y"},   Y_q,     32'h0);
        chk({tag, ".ZL"},  Zlow_q,  32'h0);
        chk({tag, ".ZH"},  Zhigh_q, 32'h0);
    endtask

    task automatic apply_reset_midcycle(input string tag);
        #2 Resetn = 1'b0;
        #1 check_all_zero(tag);
        for (int i = 0; i < NREG; i++) mr[i] = 32'h0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input string tag, input logic [31:0] val, input int dst);
        Mdatain = val; Read = 1'b1; MDRin = 1'b1;
        step({tag, ".ld"});
        MDRout = 1'b1;
        if (dst == I_R1) R1in = 1'b1;
        if (dst == I_R2) R2in = 1'b1;
        if (dst == I_R3) R3in = 1'b1;
        step({tag, ".mv"});
    endtask

    initial begin
        clr_strobes();
        Mdatain = 32'h0;
        for (int i = 0; i < NREG; i++) mr[i] = 32'h0;
        Resetn = 1'b1;
        #1 Resetn = 1'b0;
        #1 check_all_zero("rst_init");
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        preload("pre_r2", 32'h12, I_R2);
        chk("pre_r2_lit", R2_q, 32'h12);
        preload("pre_r3", 32'h14, I_R3);
        chk("pre_r3_lit", R3_q, 32'h14);
        preload("pre_r1", 32'h18, I_R1);
        chk("pre_r1_lit", R1_q, 32'h18);

        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        step("T0");
        chk("T0_mar", MAR_q, 32'h0);
        chk("T0_zlow", Zlow_q, 32'h1);
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h28918000;
        step("T1");
        chk("T1_pc", PC_q, 32'h1);
        chk("T1_mdr", MDR_q, 32'h28918000);
        MDRout = 1'b1; IRin = 1'b1;
        step("T2");
        chk("T2_ir", IR_q, 32'h28918000);

        R2out = 1'b1; Yin = 1'b1;
        step("T3");
        chk("T3_y", Y_q, 32'h12);
        R3out = 1'b1; AND = 1'b1; Zin = 1'b1;
        step("T4");
        chk("T4_zlow", Zlow_q, 32'h10);
        chk("T4_zhigh", Zhigh_q, 32'h0);
        Zlowout = 1'b1; R1in = 1'b1;
        step("T5");
        chk("T5_r1", R1_q, 32'h10);

        MDRout = 1'b1; R2out = 1'b1;
        #1 chk("prio_mdr_r2", BusMuxOut, 32'h28918000);
        clr_strobes();
        #1 chk("prio_none", BusMuxOut, 32'h0);

        Mdatain = 32'hFFFFFFFF; Read = 1'b1; MDRin = 1'b1;
        step("ff_ld");
        MDRout = 1'b1; IncPC = 1'b1; AND = 1'b1; Zin = 1'b1;
        step("inc_wrap");
        chk("inc_wrap_zl", Zlow_q, 32'h0);
        chk("inc_wrap_zh", Zhigh_q, 32'h0);

        MDRout = 1'b1; Yin = 1'b1; R2in = 1'b1; PCin = 1'b1;
        step("multi_load");

        apply_reset_midcycle("rst_mid");

        for (int n = 0; n < 300; n++) begin
            {PCout, Zlowout, MDRout, R2out, R3out} = 5'($urandom);
            if ($urandom_range(0, 3) == 0) {PCout, Zlowout, MDRout, R2out, R3out} = '0;
            {MARin, Zin, PCin, MDRin, IRin, Yin} = 6'($urandom);
            {IncPC, Read, AND, R1in, R2in, R3in} = 6'($urandom);
            Mdatain = $urandom;
            step("rnd");
            if (n == 150) apply_reset_midcycle("rst_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
